// File: rtl/alu54_acc.sv
// Two-stage signed add/subtract engine with a dout-feedback accumulate path.
// Stage 1 registers sign-extended operands; stage 2 performs a single three-term add into dout.
module alu54_acc #(
   parameter int DW = 32,
   parameter int AW = 54
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ce,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          acc_clr,
   output logic [AW-1:0] dout,
   output logic          out_valid,
   output logic          ovf
);

   logic          v1_q, v1_d;
   logic [1:0]    op_q, op_d;
   logic [AW-1:0] a_q, a_d;
   logic [AW-1:0] b_q, b_d;
   logic [AW-1:0] dout_q, dout_d;
   logic          out_valid_q, out_valid_d;
   logic          ovf_q, ovf_d;

   logic [AW:0]   fb_x, a_x, b_x, res;

   assign in_ready = ce;

   always_comb begin
      v1_d = v1_q;
      op_d = op_q;
      a_d  = a_q;
      b_d  = b_q;
      if (ce) begin
         v1_d = in_valid;
         // operand registers only toggle for real transfers
         if (in_valid) begin
            op_d = op;
            a_d  = {{(AW-DW){a[DW-1]}}, a};
            b_d  = {{(AW-DW){b[DW-1]}}, b};
         end
      end
   end

   // One AW+1-bit add: feedback + A + (B or ~B) with carry-in for subtract.
   always_comb begin
      fb_x = (op_q[1] && !acc_clr) ? {dout_q[AW-1], dout_q} : '0;
      a_x  = {a_q[AW-1], a_q};
      b_x  = op_q[0] ? ~{b_q[AW-1], b_q} : {b_q[AW-1], b_q};
      res  = fb_x + a_x + b_x + (AW+1)'(op_q[0]);
   end

   always_comb begin
      dout_d      = dout_q;
      out_valid_d = out_valid_q;
      ovf_d       = ovf_q;
      if (ce) begin
         if (v1_q) begin
            dout_d      = res[AW-1:0];
            out_valid_d = 1'b1;
            ovf_d       = res[AW] != res[AW-1];
         end else begin
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
            if (acc_clr) dout_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q        <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         v1_q        <= v1_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign dout      = dout_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu54_acc.sv
// Drives an AW=54 and an AW=40 instance with identical stimulus and checks both
// against a cycle-level arithmetic model using longint sums and modular wrap.
module tb_alu54_acc;

   logic              clk = 1'b0;
   logic              reset, ce, in_valid, acc_clr;
   logic [1:0]        op;
   logic [31:0]       a, b;
   logic              in_ready54, in_ready40;
   logic signed [53:0] dout54;
   logic signed [39:0] dout40;
   logic              ov54, ov40, ovf54, ovf40;

   int n_chk = 0;
   int n_err = 0;

   alu54_acc #(.DW(32), .AW(54)) dut54 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready54),
      .op(op), .a(a), .b(b), .acc_clr(acc_clr),
      .dout(dout54), .out_valid(ov54), .ovf(ovf54));

   alu54_acc #(.DW(32), .AW(40)) dut40 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready40),
      .op(op), .a(a), .b(b), .acc_clr(acc_clr),
      .dout(dout40), .out_valid(ov40), .ovf(ovf40));

   always #5 clk = ~clk;

   // reference state: the pending accepted operand set and each instance's result
   int     aw [2] = '{54, 40};
   bit     p_v;
   bit [1:0] p_op;
   longint p_a, p_b;
   longint m_dout [2];
   bit     m_ovf  [2];
   bit     m_ov;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic longint wrap(input longint x, input int w);
      return (x <<< (64 - w)) >>> (64 - w);
   endfunction

   task automatic step(input bit rst, input bit ce_i, input bit iv, input bit [1:0] o,
                       input logic [31:0] ai, input logic [31:0] bi, input bit clr);
      longint fb, r;
      reset = rst; ce = ce_i; in_valid = iv; op = o; a = ai; b = bi; acc_clr = clr;
      @(posedge clk);
      if (rst) begin
         p_v = 0; m_ov = 0;
         for (int k = 0; k < 2; k++) begin m_dout[k] = 0; m_ovf[k] = 0; end
      end else if (ce_i) begin
         for (int k = 0; k < 2; k++) begin
            if (p_v) begin
               fb = (p_op[1] && !clr) ? m_dout[k] : 0;
               r  = fb + p_a + (p_op[0] ? -p_b : p_b);
               m_dout[k] = wrap(r, aw[k]);
               m_ovf[k]  = (m_dout[k] != r);
            end else begin
               m_ovf[k] = 0;
               if (clr) m_dout[k] = 0;
            end
         end
         m_ov = p_v;
         p_v  = iv;
         p_op = o;
         p_a  = longint'($signed(ai));
         p_b  = longint'($signed(bi));
      end
      #1;
      chk("in_ready54", longint'(in_ready54), longint'(ce_i));
      chk("in_ready40", longint'(in_ready40), longint'(ce_i));
      chk("dout54", dout54, m_dout[0]);
      chk("dout40", dout40, m_dout[1]);
      chk("out_valid54", longint'(ov54), longint'(m_ov));
      chk("out_valid40", longint'(ov40), longint'(m_ov));
      chk("ovf54", longint'(ovf54), longint'(m_ovf[0]));
      chk("ovf40", longint'(ovf40), longint'(m_ovf[1]));
   endtask

   localparam logic [31:0] MAXP = 32'h7FFF_FFFF;

   initial begin
      int     first_ovf, n_ovf, exp_idx;
      longint acc, lim;
      logic [31:0] ra, rb;

      p_v = 0; m_ov = 0;
      for (int k = 0; k < 2; k++) begin m_dout[k] = 0; m_ovf[k] = 0; end

      // reset held two cycles with in_valid high, then release
      step(1, 1, 1, 2'b00, 5, 5, 0);
      chk("rst_dout", dout54, 0);
      step(1, 1, 1, 2'b00, 5, 5, 0);
      chk("rst_ov", longint'(ov54), 0);
      step(0, 1, 0, 2'b00, 0, 0, 0);
      chk("rst_release_ov", longint'(ov54), 0);

      // add then subtract
      step(0, 1, 1, 2'b00, 5, 7, 0);
      step(0, 1, 1, 2'b01, 0, 1, 0);
      chk("add12", dout54, 12);
      step(0, 1, 0, 2'b00, 0, 0, 0);
      chk("sub_m1", longint'(dout54[53:0]), 64'h3F_FFFF_FFFF_FFFF);
      chk("sub_ovf", longint'(ovf54), 0);
      step(0, 1, 0, 2'b00, 0, 0, 0);
      chk("pulse_one", longint'(ov54), 0);

      // back-to-back accumulate after an idle clear
      step(0, 1, 0, 2'b00, 0, 0, 1);
      step(0, 1, 1, 2'b10, MAXP, MAXP, 0);
      step(0, 1, 1, 2'b10, MAXP, MAXP, 0);
      chk("acc1", dout54, 64'hFFFF_FFFE);
      step(0, 1, 1, 2'b10, MAXP, MAXP, 0);
      chk("acc2", dout54, 64'h1_FFFF_FFFC);
      step(0, 1, 0, 2'b00, 0, 0, 0);
      chk("acc3", dout54, 64'h2_FFFF_FFFA);
      chk("acc3_ov", longint'(ov54), 1);

      // acc_clr meets an accumulate in stage 2
      step(0, 1, 1, 2'b00, 60, 40, 0);
      step(0, 1, 1, 2'b10, 3, 4, 0);
      chk("set100", dout54, 100);
      step(0, 1, 0, 2'b00, 0, 0, 1);
      chk("clr_coll", dout54, 7);

      // ce stall: inputs and acc_clr ignored while ce low
      step(0, 1, 1, 2'b00, 1, 2, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 2'b11, 32'h1234, 32'h55, 1);
         chk("stall_dout", dout54, 7);
      end
      step(0, 1, 0, 2'b00, 0, 0, 0);
      chk("stall_res", dout54, 3);
      chk("stall_ov", longint'(ov54), 1);
      step(0, 1, 0, 2'b00, 0, 0, 0);
      chk("stall_once", longint'(ov54), 0);

      // overflow on the 40-bit instance: repeated max accumulate from zero
      lim = (longint'(1) <<< 39) - 1;
      acc = 0; exp_idx = 0;
      for (int n = 1; n < 200 && exp_idx == 0; n++) begin
         acc += 2 * longint'(MAXP);
         if (acc > lim) exp_idx = n;
      end
      step(0, 1, 0, 2'b00, 0, 0, 1);
      first_ovf = 0; n_ovf = 0;
      for (int i = 0; i <= 135; i++) begin
         step(0, 1, (i < 135), 2'b10, MAXP, MAXP, 0);
         if (i >= 1 && ovf40) begin
            n_ovf++;
            if (first_ovf == 0) begin
               first_ovf = i;
               chk("wrap_neg", longint'(dout40 < 0), 1);
            end
         end
      end
      chk("ovf40_idx", first_ovf, exp_idx);
      chk("ovf40_count", n_ovf, 1);

      // reset the edge after accept drops the op
      step(0, 1, 1, 2'b00, 5, 5, 0);
      step(1, 1, 0, 2'b00, 0, 0, 0);
      step(0, 1, 0, 2'b00, 0, 0, 0);
      chk("rst_mid_ov", longint'(ov54), 0);
      chk("rst_mid_dout", dout54, 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(3))
            0: ra = MAXP;
            1: ra = 32'h8000_0000;
            default: ra = $urandom;
         endcase
         rb = ($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom;
         step(($urandom_range(60) == 0), ($urandom_range(4) != 0), $urandom_range(1),
              2'($urandom), ra, rb, ($urandom_range(7) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
